// File: rtl/dcache_ctrl_if.sv
// CPU-side and RAM-side handshake bundle for dcache_ctrl.
// The slave modport is the cache controller's view; master is the environment's view.
interface dcache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with
// 4-word lines. Hits complete in one cycle; misses write back a dirty line
// and then refill it over a chip-select/ack RAM handshake.
// Optional macro DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_ctrl #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 28 - INDEX_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  logic [1:0]             state;
  logic [1:0]             cnt;
  logic [LINES-1:0]       valid;
  logic [LINES-1:0]       dirty;
  logic [TAG_W-1:0]       tags [LINES];
  logic [31:0]            data [LINES*4];

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] idx;
  logic [1:0]             wsel;
  logic                   hit;
  logic                   lookup;
  logic                   unused_addr_bits;

  assign req_tag          = bus.cpu_addr[31:INDEX_WIDTH+4];
  assign idx              = bus.cpu_addr[INDEX_WIDTH+3:4];
  assign wsel             = bus.cpu_addr[3:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign hit              = valid[idx] && (tags[idx] == req_tag);
  // The ack cycle is skipped so a request still high then is not replayed.
  assign lookup           = (state == S_IDLE) && bus.cpu_req && !bus.cpu_ack;
  assign bus.cpu_stall    = bus.cpu_req & ~bus.cpu_ack;

  // RAM-side outputs: cs drops during the ack cycle so the RAM idles between words.
  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      S_WB: begin
        bus.mem_cs    = ~bus.mem_ack;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tags[idx], idx, cnt, 2'b00};
        bus.mem_wdata = data[{idx, cnt}];
      end
      S_REFILL: begin
        bus.mem_cs    = ~bus.mem_ack;
        bus.mem_addr  = {req_tag, idx, cnt, 2'b00};
      end
      default: ;
    endcase
  end

  // Data and tag arrays: store hits and refill words; not reset.
  always_ff @(posedge clk) begin
    if (lookup && hit && bus.cpu_we)
      data[{idx, wsel}] <= bus.cpu_wdata;
    if (state == S_REFILL && bus.mem_ack) begin
      data[{idx, cnt}] <= bus.mem_rdata;
      if (cnt == 2'd3)
        tags[idx] <= req_tag;
    end
  end

  // Controller FSM, line status bits and CPU response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 2'd0;
      valid         <= '0;
      dirty         <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lookup) begin
            if (hit) begin
              bus.cpu_ack <= 1'b1;
              if (bus.cpu_we)
                dirty[idx] <= 1'b1;
              else
                bus.cpu_rdata <= data[{idx, wsel}];
            end else begin
              cnt   <= 2'd0;
              state <= (valid[idx] && dirty[idx]) ? S_WB : S_REFILL;
            end
          end
        end
        S_WB: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3)
              state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[idx] <= 1'b1;
              dirty[idx] <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic refilled;

  // Statistics: a hit after a refill belongs to the miss and is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      refilled   <= 1'b0;
    end else if (lookup) begin
      if (hit) begin
        if (!refilled)
          hit_count <= hit_count + 32'd1;
        refilled <= 1'b0;
      end else begin
        miss_count <= miss_count + 32'd1;
        refilled   <= 1'b1;
      end
    end
  end
`endif

endmodule
